ssd_display_arbiter: RTL

- Owns the 8-digit seven-segment display on the Nexys4 DDR board and time-multiplexes its anodes.
- Shares the display between two requesters: A (normal, e.g. reaction-time result) and B (priority, e.g. status/test-mode message).
- Grants ownership and reloads displayed content only at frame boundaries, so the display never shows a mix of old and new data.
- Outputs the active-low anode vector plus a 4-bit digit code for the external seven-segment decoder.

---
 rtl/ssd_display_arbiter_if.sv | 26 ++
 rtl/ssd_display_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ssd_display_arbiter_if.sv
// Requester-side bus for the seven-segment display arbiter: two level
// requests with their digit payloads, and the two ownership grants.
interface ssd_display_arbiter_if;
    logic        a_req;
    logic [31:0] a_data;
    logic [7:0]  a_mask;
    logic        b_req;
    logic [31:0] b_data;
    logic [7:0]  b_mask;
    logic        a_gnt;
    logic        b_gnt;

    // Requester side: drives requests and content, observes grants
    modport master (
        output a_req, a_data, a_mask,
        output b_req, b_data, b_mask,
        input  a_gnt, b_gnt
    );

    // Arbiter side: observes requests and content, drives grants
    modport slave (
        input  a_req, a_data, a_mask,
        input  b_req, b_data, b_mask,
        output a_gnt, b_gnt
    );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Time-multiplexes the 8-digit seven-segment display and shares it between
// a normal requester (A) and a non-preemptible priority requester (B).
// Ownership changes and content reloads happen only at frame boundaries.
module ssd_display_arbiter #(
    parameter int unsigned REFRESH_DIV     = 100_000,
    parameter int unsigned MIN_HOLD_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ssd_display_arbiter_if.slave  bus,
    output logic [7:0]            ssdAnode,
    output logic [3:0]            ssdDigit,
    output logic                  frame_done
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(MIN_HOLD_FRAMES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    logic [CNT_W-1:0]  tick_cnt;
    logic [2:0]        idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [31:0]       shadow_data;
    logic [7:0]        shadow_mask;
    logic [31:0]       load_data;
    logic [7:0]        load_mask;
    logic              a_gnt;
    logic              b_gnt;

    logic              tick_c;
    logic              frame_end_c;
    logic [HOLD_W-1:0] hold_inc_c;
    logic              hold_met_c;

    assign bus.a_gnt = a_gnt;
    assign bus.b_gnt = b_gnt;

    // Slot timing: a tick at the terminal count, frame end on the last slot's tick
    assign tick_c      = (tick_cnt == CNT_W'(REFRESH_DIV - 1));
    assign frame_end_c = tick_c && (idx == 3'd7);

    // Frames owned including the one now ending, saturating at the hold limit
    assign hold_inc_c = (hold_cnt == HOLD_W'(MIN_HOLD_FRAMES)) ? hold_cnt
                                                                : hold_cnt + HOLD_W'(1);
    assign hold_met_c = (hold_inc_c >= HOLD_W'(MIN_HOLD_FRAMES));

    // Grant state register; only advances at frame end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (frame_end_c) begin
            state <= state_nxt;
        end
    end

    // Next-state decision and content selection for the new owner
    always_comb begin
        state_nxt = state;
        load_data = 32'd0;
        load_mask = 8'd0;
        case (state)
            ST_IDLE: begin
                if (bus.b_req)      state_nxt = ST_OWN_B;
                else if (bus.a_req) state_nxt = ST_OWN_A;
            end
            ST_OWN_A: begin
                if (!bus.a_req)                  state_nxt = bus.b_req ? ST_OWN_B : ST_IDLE;
                else if (bus.b_req && hold_met_c) state_nxt = ST_OWN_B;
            end
            ST_OWN_B: begin
                if (!bus.b_req) state_nxt = bus.a_req ? ST_OWN_A : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_OWN_A) begin
            load_data = bus.a_data;
            load_mask = bus.a_mask;
        end else if (state_nxt == ST_OWN_B) begin
            load_data = bus.b_data;
            load_mask = bus.b_mask;
        end
    end

    // Scan counters, hold counter, shadow content and grants
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt    <= '0;
            idx         <= 3'd0;
            hold_cnt    <= '0;
            shadow_data <= 32'd0;
            shadow_mask <= 8'd0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            tick_cnt   <= tick_c ? '0 : tick_cnt + CNT_W'(1);
            frame_done <= frame_end_c;
            if (tick_c) begin
                idx <= idx + 3'd1;
            end
            if (frame_end_c) begin
                hold_cnt    <= (state_nxt != state) ? '0 : hold_inc_c;
                shadow_data <= load_data;
                shadow_mask <= load_mask;
                a_gnt       <= (state_nxt == ST_OWN_A);
                b_gnt       <= (state_nxt == ST_OWN_B);
            end
        end
    end

    // Display drive for the current slot, one cycle behind the index
    always_ff @(posedge clk) begin
        if (reset) begin
            ssdAnode <= 8'hFF;
            ssdDigit <= 4'd0;
        end else begin
            ssdAnode <= shadow_mask[idx] ? ~(8'd1 << idx) : 8'hFF;
            ssdDigit <= shadow_data[{idx, 2'b00} +: 4];
        end
    end

endmodule
